// File: rtl/substitution_stream_decoder_if.sv
// substitution_stream_decoder_if: key-load, character stream and statistics bundle
interface substitution_stream_decoder_if #(
    parameter int SYMBOL_W    = 8,
    parameter int NUM_SYMBOLS = 12,
    parameter int CNT_W       = 16
);
    localparam int KEY_IDX_W = $clog2(NUM_SYMBOLS);
    logic                 key_we;
    logic [KEY_IDX_W-1:0] key_idx;
    logic                 key_en;
    logic [SYMBOL_W-1:0]  key_cipher;
    logic [SYMBOL_W-1:0]  key_plain;
    logic                 mode;
    logic                 in_valid;
    logic                 in_ready;
    logic [SYMBOL_W-1:0]  in_char;
    logic                 out_valid;
    logic                 out_ready;
    logic [SYMBOL_W-1:0]  out_char;
    logic                 out_miss;
    logic                 clr_stats;
    logic [CNT_W-1:0]     char_count;
    logic [CNT_W-1:0]     miss_count;

    modport master (
        output key_we, key_idx, key_en, key_cipher, key_plain, mode,
               in_valid, in_char, out_ready, clr_stats,
        input  in_ready, out_valid, out_char, out_miss, char_count, miss_count
    );
    modport slave (
        input  key_we, key_idx, key_en, key_cipher, key_plain, mode,
               in_valid, in_char, out_ready, clr_stats,
        output in_ready, out_valid, out_char, out_miss, char_count, miss_count
    );
endinterface

// File: rtl/substitution_stream_decoder.sv
// substitution_stream_decoder: table-driven substitution cipher with loadable key,
// miss flagging, output FIFO and statistics counters
module substitution_stream_decoder #(
    parameter int SYMBOL_W    = 8,
    parameter int NUM_SYMBOLS = 12,
    parameter int FIFO_DEPTH  = 4,
    parameter int CNT_W       = 16
) (
    input logic clk,
    input logic rst_n,
    substitution_stream_decoder_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic                tbl_en     [NUM_SYMBOLS];
    logic [SYMBOL_W-1:0] tbl_cipher [NUM_SYMBOLS];
    logic [SYMBOL_W-1:0] tbl_plain  [NUM_SYMBOLS];
    logic [SYMBOL_W-1:0] fifo_char  [FIFO_DEPTH];
    logic                fifo_miss  [FIFO_DEPTH];
    logic [PTR_W:0]      wr_ptr, rd_ptr;
    logic [SYMBOL_W-1:0] result;
    logic                miss, empty, full, push, pop, key_ok;

    // Descending scan so the lowest matching index is the last to assign
    always_comb begin
        result = bus.in_char;
        miss   = 1'b1;
        for (int i = NUM_SYMBOLS - 1; i >= 0; i--)
            if (tbl_en[i] && (bus.mode ? tbl_plain[i] : tbl_cipher[i]) == bus.in_char) begin
                result = bus.mode ? tbl_cipher[i] : tbl_plain[i];
                miss   = 1'b0;
            end
    end

    assign key_ok        = bus.key_we && int'(bus.key_idx) < NUM_SYMBOLS;
    assign empty         = wr_ptr == rd_ptr;
    assign full          = (wr_ptr ^ rd_ptr) == {1'b1, {PTR_W{1'b0}}};
    assign push          = bus.in_valid && !full;
    assign pop           = bus.out_ready && !empty;
    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;
    assign bus.out_char  = empty ? '0 : fifo_char[rd_ptr[PTR_W-1:0]];
    assign bus.out_miss  = !empty && fifo_miss[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SYMBOLS; i++)
                tbl_en[i] <= 1'b0;
        end else if (key_ok) begin
            tbl_en[bus.key_idx] <= bus.key_en;
        end
    end

    always_ff @(posedge clk) begin
        if (key_ok) begin
            tbl_cipher[bus.key_idx] <= bus.key_cipher;
            tbl_plain[bus.key_idx]  <= bus.key_plain;
        end
        if (push) begin
            fifo_char[wr_ptr[PTR_W-1:0]] <= result;
            fifo_miss[wr_ptr[PTR_W-1:0]] <= miss;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            bus.char_count <= '0;
            bus.miss_count <= '0;
        end else begin
            wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
            if (bus.clr_stats) begin
                bus.char_count <= '0;
                bus.miss_count <= '0;
            end else if (push) begin
                bus.char_count <= bus.char_count + 1'b1;
                bus.miss_count <= (miss && !(&bus.miss_count)) ? bus.miss_count + 1'b1 : bus.miss_count;
            end
        end
    end
endmodule

// File: tb/tb_substitution_stream_decoder.sv
// tb_substitution_stream_decoder: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the cipher stream
module tb_substitution_stream_decoder;
    localparam int NS    = 12;
    localparam int DEPTH = 4;
    localparam int CW    = 8;

    typedef struct packed {
        logic [7:0] c;
        logic       m;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    ent_t       exp_q[$];
    logic       m_en [NS];
    logic [7:0] m_ci [NS];
    logic [7:0] m_pl [NS];
    int         m_chars, m_miss;

    always #5 clk = ~clk;

    substitution_stream_decoder_if #(.CNT_W(CW)) bus();
    substitution_stream_decoder #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    function automatic ent_t ref_lookup(input logic md, input logic [7:0] c);
        for (int i = 0; i < NS; i++)
            if (m_en[i] && (md ? m_pl[i] : m_ci[i]) == c)
                return '{c: (md ? m_ci[i] : m_pl[i]), m: 1'b0};
        return '{c: c, m: 1'b1};
    endfunction

    function automatic ent_t head();
        return exp_q.size() > 0 ? exp_q[0] : '0;
    endfunction

    task automatic set_idle();
        bus.key_we = 0; bus.key_idx = '0; bus.key_en = 0; bus.key_cipher = '0; bus.key_plain = '0;
        bus.mode = 0; bus.in_valid = 0; bus.in_char = '0; bus.out_ready = 0; bus.clr_stats = 0;
    endtask

    // One clock edge; the model follows the stream rules with the inputs currently driven
    task automatic step();
        bit   acc = bus.in_valid && exp_q.size() < DEPTH;
        bit   pop = bus.out_ready && exp_q.size() > 0;
        ent_t e   = ref_lookup(bus.mode, bus.in_char);
        if (pop) void'(exp_q.pop_front());
        if (acc) exp_q.push_back(e);
        if (bus.key_we && int'(bus.key_idx) < NS) begin
            m_en[bus.key_idx] = bus.key_en;
            m_ci[bus.key_idx] = bus.key_cipher;
            m_pl[bus.key_idx] = bus.key_plain;
        end
        if (bus.clr_stats) begin
            m_chars = 0;
            m_miss  = 0;
        end else if (acc) begin
            m_chars = (m_chars + 1) % (1 << CW);
            if (e.m && m_miss < (1 << CW) - 1) m_miss++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_idle();
        rst_n = 0;
        @(posedge clk);
        #1;
        exp_q.delete();
        for (int i = 0; i < NS; i++) m_en[i] = 0;
        m_chars = 0;
        m_miss  = 0;
        rst_n = 1;
    endtask

    task automatic write_key(input int idx, input logic en, input logic [7:0] ci, input logic [7:0] pl);
        bus.key_we = 1; bus.key_idx = 4'(idx); bus.key_en = en; bus.key_cipher = ci; bus.key_plain = pl;
        step();
        bus.key_we = 0;
    endtask

    task automatic send(input logic [7:0] c);
        bus.in_valid = 1;
        bus.in_char  = c;
        step();
        bus.in_valid = 0;
    endtask

    task automatic test_reset();
        set_idle();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.out_valid, bus.out_char, bus.out_miss} !== 10'd0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b char=%h miss=%b want all 0", bus.out_valid, bus.out_char, bus.out_miss);
        end
        checks++;
        if (bus.char_count !== 8'd0 || bus.miss_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_counters: got %0d/%0d want 0/0", bus.char_count, bus.miss_count);
        end
        do_reset();
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_basic_decode();
        logic [7:0] msg [3] = '{8'h48, 8'h41, 8'h48};
        logic [7:0] exp [3] = '{8'h54, 8'h45, 8'h54};
        write_key(0, 1, 8'h48, 8'h54);
        write_key(1, 1, 8'h41, 8'h45);
        bus.out_ready = 1;
        for (int k = 0; k < 3; k++) begin
            bus.in_valid = 1;
            bus.in_char  = msg[k];
            step();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_char !== exp[k] || bus.out_miss !== 1'b0) begin
                errors++;
                $display("FAIL decode_%0d: got v=%b c=%h m=%b want v=1 c=%h m=0", k, bus.out_valid, bus.out_char, bus.out_miss, exp[k]);
            end
        end
        bus.in_valid = 0;
        checks++;
        if (bus.char_count !== 8'd3) begin
            errors++;
            $display("FAIL decode_char_count: got %0d want 3", bus.char_count);
        end
        step();
    endtask

    task automatic test_miss();
        send(8'h5A);
        checks++;
        if (bus.out_char !== 8'h5A || bus.out_miss !== 1'b1 || bus.miss_count !== 8'd1) begin
            errors++;
            $display("FAIL miss_z: got c=%h m=%b cnt=%0d want c=5a m=1 cnt=1", bus.out_char, bus.out_miss, bus.miss_count);
        end
        step();
        write_key(0, 0, 8'h48, 8'h54);
        send(8'h48);
        checks++;
        if (bus.out_char !== 8'h48 || bus.out_miss !== 1'b1) begin
            errors++;
            $display("FAIL miss_deleted: got c=%h m=%b want c=48 m=1", bus.out_char, bus.out_miss);
        end
        step();
    endtask

    task automatic test_encode_priority();
        bus.mode = 1;
        send(8'h45);
        checks++;
        if (bus.out_char !== 8'h41 || bus.out_miss !== 1'b0) begin
            errors++;
            $display("FAIL encode_e: got c=%h m=%b want c=41 m=0", bus.out_char, bus.out_miss);
        end
        step();
        write_key(3, 1, 8'h51, 8'h45);
        send(8'h45);
        checks++;
        if (bus.out_char !== 8'h41 || bus.out_miss !== 1'b0) begin
            errors++;
            $display("FAIL encode_priority: got c=%h m=%b want c=41 m=0", bus.out_char, bus.out_miss);
        end
        step();
        bus.mode = 0;
    endtask

    task automatic test_backpressure();
        bus.out_ready = 0;
        bus.in_valid  = 1;
        for (int k = 0; k < 6; k++) begin
            bus.in_char = 8'h41 + 8'($urandom_range(0, 20));
            checks++;
            if (bus.in_ready !== (k < DEPTH)) begin
                errors++;
                $display("FAIL bp_in_ready_%0d: got %b want %b", k, bus.in_ready, k < DEPTH);
            end
            step();
            checks++;
            if ({bus.out_char, bus.out_miss} !== head()) begin
                errors++;
                $display("FAIL bp_head_%0d: got %h/%b want %h/%b", k, bus.out_char, bus.out_miss, head().c, head().m);
            end
        end
        bus.in_valid  = 0;
        bus.out_ready = 1;
        step();
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_drain_ready: got %b want 1", bus.in_ready);
        end
        for (int k = 0; k < DEPTH && exp_q.size() > 0; k++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || {bus.out_char, bus.out_miss} !== head()) begin
                errors++;
                $display("FAIL bp_order_%0d: got v=%b %h/%b want %h/%b", k, bus.out_valid, bus.out_char, bus.out_miss, head().c, head().m);
            end
            step();
        end
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_char !== 8'h00) begin
            errors++;
            $display("FAIL bp_empty: got v=%b c=%h want v=0 c=00", bus.out_valid, bus.out_char);
        end
    endtask

    task automatic test_collision();
        bus.out_ready  = 1;
        bus.key_we     = 1; bus.key_idx = 4'd1; bus.key_en = 1; bus.key_cipher = 8'h41; bus.key_plain = 8'h58;
        bus.in_valid   = 1; bus.in_char = 8'h41;
        step();
        bus.key_we = 0;
        checks++;
        if (bus.out_char !== 8'h45) begin
            errors++;
            $display("FAIL collision_old: got %h want 45", bus.out_char);
        end
        step();
        bus.in_valid = 0;
        checks++;
        if (bus.out_char !== 8'h58) begin
            errors++;
            $display("FAIL collision_new: got %h want 58", bus.out_char);
        end
        step();
    endtask

    task automatic test_reset_midstream();
        bus.out_ready = 0;
        bus.in_valid  = 1;
        for (int k = 0; k < 3; k++) begin
            bus.in_char = 8'h41 + 8'(k);
            step();
        end
        do_reset();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.char_count !== 8'd0 || bus.miss_count !== 8'd0) begin
            errors++;
            $display("FAIL midreset: got v=%b rdy=%b cnt=%0d/%0d want 0 1 0/0", bus.out_valid, bus.in_ready, bus.char_count, bus.miss_count);
        end
        bus.out_ready = 1;
        send(8'h41);
        checks++;
        if (bus.out_char !== 8'h41 || bus.out_miss !== 1'b1) begin
            errors++;
            $display("FAIL midreset_lookup: got %h/%b want 41/1", bus.out_char, bus.out_miss);
        end
        step();
    endtask

    task automatic test_counters();
        bus.out_ready = 1;
        bus.in_valid  = 1;
        repeat (260) begin
            bus.in_char = 8'($urandom_range(0, 255));
            step();
        end
        bus.in_valid = 0;
        checks++;
        if (bus.miss_count !== 8'hFF) begin
            errors++;
            $display("FAIL miss_saturate: got %h want ff", bus.miss_count);
        end
        checks++;
        if (bus.char_count !== CW'(m_chars)) begin
            errors++;
            $display("FAIL char_wrap: got %0d want %0d", bus.char_count, m_chars);
        end
        bus.clr_stats = 1;
        send(8'h5A);
        bus.clr_stats = 0;
        checks++;
        if (bus.char_count !== 8'd0 || bus.miss_count !== 8'd0) begin
            errors++;
            $display("FAIL clr_priority: got %0d/%0d want 0/0", bus.char_count, bus.miss_count);
        end
        step();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            bus.key_we     = $urandom_range(0, 3) == 0;
            bus.key_idx    = 4'($urandom_range(0, 15));
            bus.key_en     = $urandom_range(0, 3) != 0;
            bus.key_cipher = 8'h41 + 8'($urandom_range(0, 7));
            bus.key_plain  = 8'h41 + 8'($urandom_range(0, 7));
            bus.mode       = 1'($urandom_range(0, 1));
            bus.in_valid   = $urandom_range(0, 3) != 0;
            bus.in_char    = 8'h41 + 8'($urandom_range(0, 9));
            bus.out_ready  = $urandom_range(0, 2) != 0;
            bus.clr_stats  = $urandom_range(0, 40) == 0;
            checks++;
            if (bus.in_ready !== (exp_q.size() < DEPTH) || bus.out_valid !== (exp_q.size() > 0)) begin
                errors++;
                $display("FAIL rand_flags_%0d: got rdy=%b v=%b want rdy=%b v=%b", n, bus.in_ready, bus.out_valid, exp_q.size() < DEPTH, exp_q.size() > 0);
            end
            checks++;
            if ({bus.out_char, bus.out_miss} !== head()) begin
                errors++;
                $display("FAIL rand_out_%0d: got %h/%b want %h/%b", n, bus.out_char, bus.out_miss, head().c, head().m);
            end
            checks++;
            if (bus.char_count !== CW'(m_chars) || bus.miss_count !== CW'(m_miss)) begin
                errors++;
                $display("FAIL rand_counts_%0d: got %0d/%0d want %0d/%0d", n, bus.char_count, bus.miss_count, m_chars, m_miss);
            end
            step();
        end
        set_idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic_decode();
        test_miss();
        test_encode_priority();
        test_backpressure();
        test_collision();
        test_reset_midstream();
        test_counters();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/substitution_stream_decoder.md
# substitution_stream_decoder

Streaming, table-driven substitution cipher decoder/encoder sitting between a character source and a character sink. It generalises the fixed-mapping combinational `DECODER` into a clocked block with:
- a run-time-loadable key table of `NUM_SYMBOLS` cipher/plain pairs;
- a decode/encode mode;
- explicit miss handling instead of undefined output;
- valid/ready handshakes on both sides, an output FIFO, and statistics counters.

## Interface
- `SYMBOL_W`, 8: character width in bits (ASCII).
- `NUM_SYMBOLS`, 12: number of key-table entries; ≥2.
- `FIFO_DEPTH`, 4: output FIFO entries; power of two, ≥2.
- `CNT_W`, 16: statistics counter width.
- `KEY_IDX_W`, `$clog2(NUM_SYMBOLS)`: derived; not overridden.

- `CLK` in 1: sole clock, all state on rising edge.
- `RST_N` in 1: synchronous, active-low reset.
- `KEY_WE` in 1: key-table write strobe.
- `KEY_IDX` in `KEY_IDX_W`: entry written.
- `KEY_EN` in 1: valid bit written with the entry (0 = delete entry).
- `KEY_CIPHER` in `SYMBOL_W`: cipher character of entry.
- `KEY_PLAIN` in `SYMBOL_W`: plain character of entry.
- `MODE` in 1: 0 = decode (cipher→plain), 1 = encode (plain→cipher); sampled per accepted character.
- `IN_VALID` in 1 / `IN_READY` out 1 / `IN_CHAR` in `SYMBOL_W`: input stream.
- `OUT_VALID` out 1 / `OUT_READY` in 1 / `OUT_CHAR` out `SYMBOL_W` / `OUT_MISS` out 1: output stream; `OUT_MISS` marks a character with no table match.
- `CLR_STATS` in 1: synchronous clear of both counters.
- `CHAR_COUNT` out `CNT_W`: accepted characters, wraps.
- `MISS_COUNT` out `CNT_W`: accepted characters that missed, saturates at all-ones.

## Operation
- **Reset** (`RST_N`=0 at an edge): all table valid bits 0; FIFO empty; both counters 0.
- **Outputs during and after reset:** `OUT_VALID`=0, `OUT_CHAR`=0, `OUT_MISS`=0, `IN_READY`=1 from the first cycle after reset.
- **Reset mid-stream:** discards FIFO contents and table; no partial output.
- **Key write:** on an edge with `KEY_WE`=1, entry `KEY_IDX` ← {`KEY_EN`, `KEY_CIPHER`, `KEY_PLAIN`}.
  - `KEY_IDX` ≥ `NUM_SYMBOLS`: the write is ignored.
  - Writes are allowed at any time, including while streaming.
- **Lookup:** combinational on `IN_CHAR` against all valid entries.
  - Decode compares cipher fields and returns plain; encode compares plain fields and returns cipher.
  - Several matches: the lowest index wins.
  - No match: output = `IN_CHAR` unchanged, with miss = 1.
- **Accept:** a character is accepted when `IN_VALID`&&`IN_READY`. On acceptance, {result, miss} is pushed to the FIFO, `CHAR_COUNT` increments, and `MISS_COUNT` increments if miss.
- **Write vs. accept, same edge:** the lookup uses the table contents before the write. The written entry affects only characters accepted on later edges.
- **Back-pressure:**
  - `IN_READY` = FIFO not full. There is no look-through, so `IN_READY`=0 when full even if `OUT_READY`=1.
  - Push and pop on the same edge, FIFO neither empty nor full: occupancy unchanged.
  - Pop with empty FIFO: no effect.
- **Output:** `OUT_VALID` = FIFO not empty; `OUT_CHAR`/`OUT_MISS` = head entry.
  - Output holds stable while `OUT_VALID`&&!`OUT_READY`.
  - When the FIFO is empty, `OUT_CHAR`/`OUT_MISS` are 0.
- **Ordering:** characters leave in acceptance order; none dropped or duplicated.
- **Statistics clear:** `CLR_STATS`=1 zeroes both counters and takes priority over a same-edge increment.
- **Counter limits:** `CHAR_COUNT` wraps from all-ones to 0. `MISS_COUNT` holds at all-ones.

## Timing
- **Latency:** a character accepted at edge N is presented with `OUT_VALID`=1 after edge N when the FIFO was empty. Otherwise it is presented behind the queued entries.
- **Throughput:** one character per cycle sustained when `OUT_READY`=1.
- **Fill:** with `OUT_READY`=0, exactly `FIFO_DEPTH` characters are accepted, then `IN_READY` drops after the edge that fills the FIFO.
- **Drain:** `IN_READY` rises the cycle after the first pop from full.
- **Counter and table updates:** visible the cycle after the causing edge.

## Test plan
- **Basic decode:** reset, then load entry0 'H'(0x48)→'T'(0x54) and entry1 'A'(0x41)→'E'(0x45). Stream "HAH" with `OUT_READY`=1 -> outputs 0x54, 0x45, 0x54, `OUT_MISS`=0, each one cycle after acceptance; `CHAR_COUNT`=3.
- **Miss:** same table, stream 'Z'(0x5A) -> `OUT_CHAR`=0x5A, `OUT_MISS`=1, `MISS_COUNT`=1. Then write entry0 with `KEY_EN`=0 and stream 'H' -> 0x48 with miss.
- **Encode and priority:** `MODE`=1 with the same table, stream 'E' -> 0x41. Add entry3 'Q'→'E', stream 'E' -> still 0x41 (entry1 wins).
- **Back-pressure:** `OUT_READY`=0, `IN_VALID`=1 continuously -> exactly 4 accepted, then `IN_READY`=0 and head stable. Raise `OUT_READY` -> order preserved, `IN_READY`=1 the cycle after the first pop.
- **Write/accept collision:** on the same edge, write entry1 'A'→'X' and accept 'A' -> that character outputs 'E'; the next 'A' outputs 'X'.
- **Reset and counters:** apply `RST_N`=0 with 3 entries queued -> `OUT_VALID`=0, counters 0, all lookups miss. Separately, preset `MISS_COUNT` to all-ones by streaming misses -> it saturates; `CLR_STATS` with a simultaneous accept -> both counters 0.
